// File: rtl/decode_issue.sv
// Decode/operand-fetch stage: captures an instruction, reads the register file,
// applies writeback bypass and immediate extension, and holds the ALU bundle.
module decode_issue #(
  parameter int ID_W   = 32,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       ir_in,
  output logic [NREG_W-1:0] rf_raddr1,
  output logic [NREG_W-1:0] rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic              wb_en,
  input  logic [NREG_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [31:0]       ir,
  output logic [ID_W-1:0]   ID,
  output logic [31:0]       rs,
  output logic [31:0]       rt,
  output logic [31:0]       imm,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE} state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUBI = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_ORI  = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_SLT  = 6'b010011;

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       byp1_q, byp1_d, byp2_q, byp2_d;
  logic              byp1_flag_q, byp1_flag_d, byp2_flag_q, byp2_flag_d;

  logic [NREG_W-1:0] src1, src2;
  logic [31:0]       op1, op2;
  logic [ID_W-1:0]   dec_id;
  logic [31:0]       dec_rs, dec_rt, dec_imm;
  logic              dec_illegal;
  logic              take;

  assign src1      = ir_q[25:21];
  assign src2      = ir_q[20:16];
  assign rf_raddr1 = src1;
  assign rf_raddr2 = src2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid bundle is held unchanged until that edge. Neither side
  // transfers while reset is asserted.
  assign instr_ready = !reset && ((state_q == S_IDLE) || (state_q == S_ISSUE && alu_ready));
  assign alu_valid   = !reset && (state_q == S_ISSUE);
  assign take        = instr_valid && instr_ready;

  // Operand select: $0 is hard zero, then a same-cycle write, then a write seen in FETCH.
  always_comb begin
    op1 = rf_rdata1;
    if (src1 == '0)                      op1 = '0;
    else if (wb_en && wb_addr == src1)   op1 = wb_data;
    else if (byp1_flag_q)                op1 = byp1_q;
    op2 = rf_rdata2;
    if (src2 == '0)                      op2 = '0;
    else if (wb_en && wb_addr == src2)   op2 = wb_data;
    else if (byp2_flag_q)                op2 = byp2_q;
  end

  always_comb begin
    dec_id      = '0;
    dec_rs      = '0;
    dec_rt      = '0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (ir_q[31:26])
      OP_ADD:  begin dec_id = ID_W'(1);  dec_rs = op1; dec_rt = op2; end
      OP_SUBI: begin dec_id = ID_W'(2);  dec_rs = op1; dec_rt = {{16{ir_q[15]}}, ir_q[15:0]}; end
      OP_AND:  begin dec_id = ID_W'(7);  dec_rs = op1; dec_rt = op2; end
      OP_ORI:  begin dec_id = ID_W'(10); dec_rs = op1; dec_rt = {16'b0, ir_q[15:0]}; end
      OP_LW:   begin dec_id = ID_W'(13); dec_rs = op1; dec_rt = op2; dec_imm = {{16{ir_q[15]}}, ir_q[15:0]}; end
      OP_SW:   begin dec_id = ID_W'(14); dec_rs = op1; dec_rt = op2; dec_imm = {{16{ir_q[15]}}, ir_q[15:0]}; end
      OP_J:    begin dec_id = ID_W'(21); dec_imm = {6'b0, ir_q[25:0]}; end
      OP_SLT:  begin dec_id = ID_W'(24); dec_rs = op1; dec_rt = op2; end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    id_d        = id_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    byp1_d      = byp1_q;
    byp2_d      = byp2_q;
    byp1_flag_d = byp1_flag_q;
    byp2_flag_d = byp2_flag_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          ir_d        = ir_in;
          byp1_flag_d = 1'b0;
          byp2_flag_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        // The RF samples its address at the end of this cycle and misses this write.
        if (wb_en && wb_addr == src1 && src1 != '0) begin
          byp1_flag_d = 1'b1;
          byp1_d      = wb_data;
        end
        if (wb_en && wb_addr == src2 && src2 != '0) begin
          byp2_flag_d = 1'b1;
          byp2_d      = wb_data;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        id_d      = dec_id;
        rs_d      = dec_rs;
        rt_d      = dec_rt;
        imm_d     = dec_imm;
        illegal_d = dec_illegal;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (alu_ready) begin
          if (take) begin
            ir_d        = ir_in;
            byp1_flag_d = 1'b0;
            byp2_flag_d = 1'b0;
            state_d     = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      id_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      byp1_q      <= '0;
      byp2_q      <= '0;
      byp1_flag_q <= 1'b0;
      byp2_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      id_q        <= id_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      byp1_flag_q <= byp1_flag_d;
      byp2_flag_q <= byp2_flag_d;
    end
  end

  assign ir      = ir_q;
  assign ID      = id_q;
  assign rs      = rs_q;
  assign rt      = rt_q;
  assign imm     = imm_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: synchronous RF model, directed cases then random
// instructions checked against an architectural register-value model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] ir_in;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] ir, ID, rs, rt, imm;
  logic        illegal;

  decode_issue #(.ID_W(32), .NREG_W(5)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ir_in(ir_in),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .ir(ir), .ID(ID), .rs(rs), .rt(rt), .imm(imm), .illegal(illegal)
  );

  // ---------------- clock / RF model ----------------
  always #5 clk = ~clk;

  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    rf_rdata1 <= rf_mem[rf_raddr1];
    rf_rdata2 <= rf_mem[rf_raddr2];
    if (wb_en) rf_mem[wb_addr] <= wb_data;
  end

  // ---------------- reference model ----------------
  // arch holds the newest value written to each register, as the ALU should see it.
  logic [31:0] arch [32];

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t        e;
    logic [31:0] r1, r2, sx, zx;
    r1 = (i[25:21] == 5'd0) ? 32'd0 : arch[i[25:21]];
    r2 = (i[20:16] == 5'd0) ? 32'd0 : arch[i[20:16]];
    sx = 32'($signed(i[15:0]));
    zx = 32'(i[15:0]);
    e  = '0;
    case (i[31:26])
      6'd0:  begin e.id = 1;  e.rs = r1; e.rt = r2; end
      6'd1:  begin e.id = 2;  e.rs = r1; e.rt = sx; end
      6'd3:  begin e.id = 7;  e.rs = r1; e.rt = r2; end
      6'd6:  begin e.id = 10; e.rs = r1; e.rt = zx; end
      6'd8:  begin e.id = 13; e.rs = r1; e.rt = r2; e.imm = sx; end
      6'd9:  begin e.id = 14; e.rs = r1; e.rt = r2; e.imm = sx; end
      6'd16: begin e.id = 21; e.imm = 32'(i[25:0]); end
      6'd19: begin e.id = 24; e.rs = r1; e.rt = r2; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_bundle(input string tag, input logic [31:0] instr, input exp_t e);
    check_eq({tag, "_ir"}, ir, instr);
    check_eq({tag, "_id"}, ID, e.id);
    check_eq({tag, "_rs"}, rs, e.rs);
    check_eq({tag, "_rt"}, rt, e.rt);
    check_eq({tag, "_imm"}, imm, e.imm);
    check_eq({tag, "_illegal"}, 32'(illegal), 32'(e.illegal));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    arch[a] = d;
    wb_en = 1'b0;
  endtask

  // Must be called right after step() with the DUT idle.
  task automatic present(input logic [31:0] instr);
    instr_valid = 1'b1;
    ir_in       = instr;
    @(negedge clk);
    check_eq("idle_ready", 32'(instr_ready), 32'd1);
    check_eq("idle_valid", 32'(alu_valid), 32'd0);
    step();
    instr_valid = 1'b0;
  endtask

  // Runs FETCH, WAIT and ISSUE for an already-accepted instruction.
  task automatic run_body(input logic [31:0] instr,
                          input logic fw_en, input logic [4:0] fw_a, input logic [31:0] fw_d,
                          input logic ww_en, input logic [4:0] ww_a, input logic [31:0] ww_d,
                          input int stall, input bit b2b, input logic [31:0] nxt);
    exp_t e;
    wb_en = fw_en; wb_addr = fw_a; wb_data = fw_d;
    @(negedge clk);
    check_eq("fetch_ready", 32'(instr_ready), 32'd0);
    check_eq("fetch_valid", 32'(alu_valid), 32'd0);
    check_eq("raddr1", 32'(rf_raddr1), 32'(instr[25:21]));
    check_eq("raddr2", 32'(rf_raddr2), 32'(instr[20:16]));
    step();
    if (fw_en) arch[fw_a] = fw_d;
    wb_en = ww_en; wb_addr = ww_a; wb_data = ww_d;
    @(negedge clk);
    check_eq("wait_ready", 32'(instr_ready), 32'd0);
    check_eq("wait_valid", 32'(alu_valid), 32'd0);
    step();
    if (ww_en) arch[ww_a] = ww_d;
    e = ref_decode(instr);
    for (int c = 0; c <= stall; c++) begin
      // Random writebacks during ISSUE must leave the held bundle alone.
      wb_en   = 1'($urandom_range(0, 1));
      wb_addr = $urandom_range(0, 1) ? instr[25:21] : 5'($urandom_range(0, 31));
      wb_data = $urandom;
      alu_ready = (c == stall);
      if (c == stall && b2b) begin
        instr_valid = 1'b1;
        ir_in       = nxt;
      end
      @(negedge clk);
      check_eq("issue_valid", 32'(alu_valid), 32'd1);
      check_eq("issue_ready", 32'(instr_ready), 32'(c == stall));
      check_bundle("issue", instr, e);
      step();
      if (wb_en) arch[wb_addr] = wb_data;
    end
    wb_en = 1'b0; alu_ready = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] instr,
                         input logic fw_en, input logic [4:0] fw_a, input logic [31:0] fw_d,
                         input logic ww_en, input logic [4:0] ww_a, input logic [31:0] ww_d,
                         input int stall);
    present(instr);
    run_body(instr, fw_en, fw_a, fw_d, ww_en, ww_a, ww_d, stall, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0] ops [8] = '{6'd0, 6'd1, 6'd3, 6'd6, 6'd8, 6'd9, 6'd16, 6'd19};
    int         k;
    logic [5:0] op;
    k  = $urandom_range(0, 9);
    op = (k < 8) ? ops[k] : 6'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  function automatic logic [4:0] pick_addr(input logic [31:0] instr);
    case ($urandom_range(0, 3))
      0: return instr[25:21];
      1: return instr[20:16];
      2: return 5'd0;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] cur, nxt, i_add, i_sub;
    logic        fe, we;
    logic [4:0]  fa, wa;
    bit          b2b;
    int          n_rand;

    reset = 1'b1; instr_valid = 1'b0; ir_in = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; alu_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_valid", 32'(alu_valid), 32'd0);
    check_eq("rst_ready", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    step();
    @(negedge clk);
    check_eq("rst_ready_rel", 32'(instr_ready), 32'd1);
    check_bundle("rst", 32'd0, exp_t'(0));
    step();

    for (int r = 0; r < 32; r++) wr(5'(r), $urandom);

    // add $1,$3,$5 held for 4 stalled cycles
    wr(5'd3, 32'd10); wr(5'd5, 32'd12);
    i_add = {6'd0, 5'd3, 5'd5, 5'd1, 11'd0};
    run_one(i_add, 0, 0, 0, 0, 0, 0, 4);
    check_eq("add_rs_const", rs, 32'd10);

    // immediates
    wr(5'd2, 32'd10);
    i_sub = {6'd1, 5'd2, 5'd1, 16'h0064};
    run_one(i_sub, 0, 0, 0, 0, 0, 0, 1);
    check_eq("subi_rt_const", rt, 32'd100);
    wr(5'd2, 32'd10);
    run_one({6'd1, 5'd2, 5'd1, 16'hFFF6}, 0, 0, 0, 0, 0, 0, 0);
    check_eq("subi_neg_rt", rt, 32'hFFFF_FFF6);
    run_one({6'd6, 5'd2, 5'd1, 16'h8063}, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ori_rt", rt, 32'h0000_8063);
    run_one({6'd8, 5'd3, 5'd5, 16'hFF80}, 0, 0, 0, 0, 0, 0, 0);
    run_one({6'd9, 5'd4, 5'd6, 16'h0010}, 0, 0, 0, 0, 0, 0, 0);
    run_one({6'd3, 5'd7, 5'd2, 16'h0000}, 0, 0, 0, 0, 0, 0, 0);
    run_one({6'd16, 26'd100}, 0, 0, 0, 0, 0, 0, 0);
    check_eq("j_imm", imm, 32'd100);
    run_one({6'd63, 26'h2AB_CDEF}, 0, 0, 0, 0, 0, 0, 0);
    check_eq("illegal_flag", 32'(illegal), 32'd1);

    // bypass: stale RF value in FETCH, newest write in WAIT, and $0
    wr(5'd3, 32'd17);
    run_one({6'd19, 5'd3, 5'd6, 5'd1, 11'd0}, 1, 5'd3, 32'd5, 0, 0, 0, 0);
    check_eq("byp_fetch_rs", rs, 32'd5);
    wr(5'd3, 32'd17);
    run_one({6'd19, 5'd3, 5'd6, 5'd1, 11'd0}, 1, 5'd3, 32'd7, 1, 5'd3, 32'd9, 0);
    check_eq("byp_wait_rs", rs, 32'd9);
    run_one({6'd19, 5'd0, 5'd6, 5'd1, 11'd0}, 1, 5'd0, 32'd55, 1, 5'd0, 32'd66, 0);
    check_eq("byp_r0_rs", rs, 32'd0);
    wr(5'd3, 32'd17);
    run_one({6'd0, 5'd4, 5'd3, 5'd1, 11'd0}, 1, 5'd3, 32'd21, 0, 0, 0, 1);

    // back-to-back: second instruction accepted in the release cycle
    wr(5'd3, 32'd10); wr(5'd5, 32'd12); wr(5'd2, 32'd10);
    present(i_add);
    run_body(i_add, 0, 0, 0, 0, 0, 0, 0, 1'b1, i_sub);
    run_body(i_sub, 0, 0, 0, 0, 0, 0, 2, 1'b0, 32'd0);

    // synchronous reset in WAIT discards the instruction
    present(i_add);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstw_valid", 32'(alu_valid), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstw_valid_after", 32'(alu_valid), 32'd0);
    check_eq("rstw_ready_after", 32'(instr_ready), 32'd1);
    check_bundle("rstw", 32'd0, exp_t'(0));
    step();
    run_one(i_sub, 0, 0, 0, 0, 0, 0, 0);

    // randomized run with optional back-to-back chaining
    n_rand = 60;
    cur = gen_instr();
    present(cur);
    for (int k = 0; k < n_rand; k++) begin
      nxt = gen_instr();
      b2b = (k != n_rand - 1) && ($urandom_range(0, 1) == 1);
      fe = 1'($urandom_range(0, 1)); fa = pick_addr(cur);
      we = 1'($urandom_range(0, 1)); wa = pick_addr(cur);
      run_body(cur, fe, fa, $urandom, we, wa, $urandom, $urandom_range(0, 3), b2b, nxt);
      cur = nxt;
      if (!b2b && k != n_rand - 1) present(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
